// File: rtl/fft16_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft16_sequencer_if: handshake and address bus of the FFT sequencer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fft16_sequencer_if;
  logic       i_start;
  logic       i_in_valid;
  logic       o_in_ready;
  logic       o_we;
  logic [3:0] o_wr_addr;
  logic       o_bfly_valid;
  logic [3:0] o_rd_addr_a;
  logic [3:0] o_rd_addr_b;
  logic [2:0] o_tw_idx;
  logic [1:0] o_stage;
  logic       o_wb_valid;
  logic [3:0] o_wb_addr_a;
  logic [3:0] o_wb_addr_b;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [3:0] o_out_addr;
  logic       o_busy;
  logic       o_done;

  // master is the sequencer; slave is the frame source/sink around it
  modport master (
    input  i_start, i_in_valid, i_out_ready,
    output o_in_ready, o_we, o_wr_addr, o_bfly_valid, o_rd_addr_a, o_rd_addr_b,
           o_tw_idx, o_stage, o_wb_valid, o_wb_addr_a, o_wb_addr_b,
           o_out_valid, o_out_addr, o_busy, o_done
  );

  modport slave (
    output i_start, i_in_valid, i_out_ready,
    input  o_in_ready, o_we, o_wr_addr, o_bfly_valid, o_rd_addr_a, o_rd_addr_b,
           o_tw_idx, o_stage, o_wb_valid, o_wb_addr_a, o_wb_addr_b,
           o_out_valid, o_out_addr, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/fft16_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft16_sequencer: load / 4x8 butterfly issue / unload control, 16-pt   |
// | FFT_SEQ_BITREV_EN: DIT with bit-reversed load (default: DIF, bitrev   |
// | unload).  Rev 1.0                                                     |
// +----------------------------------------------------------------------+
module fft16_sequencer #(
  parameter int BFLY_LAT = 2  // issue-to-write-back latency, 1..7
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  fft16_sequencer_if.master         bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
  } wb_entry_t;

  localparam logic [2:0] WAIT_LAST = 3'(BFLY_LAT - 1);

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Returns {a, b, tw}. e is log2 of the butterfly span; DIT grows it per
  // stage, DIF shrinks it, and tw = pos << (3-e) holds for both orderings.
  function automatic logic [10:0] bfly_ops(input logic [1:0] s, input logic [2:0] k);
    logic [1:0] e;
    logic [3:0] k4;
    logic [3:0] mask;
    logic [3:0] a;
    logic [2:0] pos;
    logic [2:0] tw;
`ifdef FFT_SEQ_BITREV_EN
    e = s;
`else
    e = 2'd3 - s;
`endif
    k4   = {1'b0, k};
    mask = (4'd1 << e) - 4'd1;
    a    = ((k4 >> e) << (e + 3'd1)) | (k4 & mask);
    pos  = k & mask[2:0];
    tw   = pos << (2'd3 - e);
    return {a, a | (4'd1 << e), tw};
  endfunction

  state_t     state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [1:0] s_q, s_d;
  logic [2:0] k_q, k_d;
  logic [2:0] wait_q, wait_d;

  logic       in_ready_q, in_ready_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic       bfly_valid_q, bfly_valid_d;
  logic [3:0] rd_a_q, rd_a_d;
  logic [3:0] rd_b_q, rd_b_d;
  logic [2:0] tw_q, tw_d;
  logic [1:0] stage_q, stage_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_addr_q, out_addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  wb_entry_t  pipe_q [BFLY_LAT];
  wb_entry_t  pipe_d [BFLY_LAT];

  logic [10:0] ops;
  logic        in_accept;
  logic        out_accept;

  assign in_accept  = bus.i_in_valid & in_ready_q;
  assign out_accept = out_valid_q & bus.i_out_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    s_d     = s_q;
    k_d     = k_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_LOAD;
          n_d     = 4'd0;
        end
      end
      ST_LOAD: begin
        if (in_accept) begin
          n_d = n_q + 4'd1;
          if (n_q == 4'd15) begin
            state_d = ST_CALC;
            s_d     = 2'd0;
            k_d     = 3'd0;
          end
        end
      end
      ST_CALC: begin
        if (k_q == 3'd7) begin
          state_d = ST_WAIT;
          wait_d  = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_WAIT: begin
        // Hold until the stage's last write-back has landed in the RAM
        if (wait_q == WAIT_LAST) begin
          k_d = 3'd0;
          if (s_q == 2'd3) begin
            state_d = ST_UNLOAD;
            n_d     = 4'd0;
            s_d     = 2'd0;
          end else begin
            state_d = ST_CALC;
            s_d     = s_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_UNLOAD: begin
        if (out_accept) begin
          n_d = n_q + 4'd1;
          if (n_q == 4'd15) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are derived from next-state values so they register in step
    ops          = bfly_ops(s_d, k_d);
    in_ready_d   = (state_d == ST_LOAD);
    bfly_valid_d = (state_d == ST_CALC);
    out_valid_d  = (state_d == ST_UNLOAD);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    stage_d      = s_d;
    rd_a_d       = bfly_valid_d ? ops[10:7] : 4'd0;
    rd_b_d       = bfly_valid_d ? ops[6:3]  : 4'd0;
    tw_d         = bfly_valid_d ? ops[2:0]  : 3'd0;
`ifdef FFT_SEQ_BITREV_EN
    wr_addr_d    = in_ready_d  ? bitrev4(n_d) : 4'd0;
    out_addr_d   = out_valid_d ? n_d          : 4'd0;
`else
    wr_addr_d    = in_ready_d  ? n_d          : 4'd0;
    out_addr_d   = out_valid_d ? bitrev4(n_d) : 4'd0;
`endif

    pipe_d[0] = {bfly_valid_q, rd_a_q, rd_b_q};
    for (int i = 1; i < BFLY_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      n_q          <= 4'd0;
      s_q          <= 2'd0;
      k_q          <= 3'd0;
      wait_q       <= 3'd0;
      in_ready_q   <= 1'b0;
      wr_addr_q    <= 4'd0;
      bfly_valid_q <= 1'b0;
      rd_a_q       <= 4'd0;
      rd_b_q       <= 4'd0;
      tw_q         <= 3'd0;
      stage_q      <= 2'd0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      s_q          <= s_d;
      k_q          <= k_d;
      wait_q       <= wait_d;
      in_ready_q   <= in_ready_d;
      wr_addr_q    <= wr_addr_d;
      bfly_valid_q <= bfly_valid_d;
      rd_a_q       <= rd_a_d;
      rd_b_q       <= rd_b_d;
      tw_q         <= tw_d;
      stage_q      <= stage_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int i = 0; i < BFLY_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign bus.o_in_ready   = in_ready_q;
  assign bus.o_we         = in_accept;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_bfly_valid = bfly_valid_q;
  assign bus.o_rd_addr_a  = rd_a_q;
  assign bus.o_rd_addr_b  = rd_b_q;
  assign bus.o_tw_idx     = tw_q;
  assign bus.o_stage      = stage_q;
  assign bus.o_wb_valid   = pipe_q[BFLY_LAT-1].v;
  assign bus.o_wb_addr_a  = pipe_q[BFLY_LAT-1].a;
  assign bus.o_wb_addr_b  = pipe_q[BFLY_LAT-1].b;
  assign bus.o_out_valid  = out_valid_q;
  assign bus.o_out_addr   = out_addr_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;

endmodule
`default_nettype wire

// File: doc/fft16_sequencer.md
# fft16_sequencer

Control sequencer for the 16-point radix-2 DIT FFT datapath. It accepts a frame of 16 samples into the working RAM and issues 4 stages × 8 butterfly operations with operand addresses and twiddle indices. It tracks butterfly write-back and hazards, then unloads 16 results in natural order. It runs in the system clock domain alongside the clock divider, and every phase is paced by handshakes rather than derived clocks.

## Interface
Parameters:
- BFLY_LAT, 2, butterfly datapath latency in cycles from issue to write-back; legal range 1..7.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  frame start request; sampled only in IDLE.
- i_in_valid  in  1  input sample valid.
- o_in_ready  out  1  high throughout LOAD.
- o_we  out  1  RAM write strobe, equal to i_in_valid & o_in_ready.
- o_wr_addr  out  4  RAM write address for the current input sample.
- o_bfly_valid  out  1  butterfly issue strobe.
- o_rd_addr_a / o_rd_addr_b  out  4 each  butterfly operand addresses.
- o_tw_idx  out  3  twiddle index k for W16^k.
- o_stage  out  2  current stage, 0..3.
- o_wb_valid  out  1  write-back strobe for butterfly results.
- o_wb_addr_a / o_wb_addr_b  out  4 each  write-back addresses.
- o_out_valid  out  1  high throughout UNLOAD.
- i_out_ready  in  1  downstream accepts the current output.
- o_out_addr  out  4  RAM read address of the current output.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, LOAD, CALC, WAIT, UNLOAD, DONE.
- IDLE:
  - i_start=1 → LOAD, with the sample counter n=0.
  - i_start in any other state is ignored.
- LOAD:
  - Each cycle with i_in_valid=1 writes sample n and increments n.
  - After the 16th write (n=15 accepted) → CALC, with s=0 and k=0.
- CALC issues one butterfly per cycle with o_bfly_valid=1, using:
  - h = 1<<s, group = k>>s, pos = k & (h-1)
  - a = group·2h + pos, b = a + h, tw = pos<<(3−s)
  - Example, s=0: (2k, 2k+1, tw=0). Example, s=3: (k, k+8, tw=k).
- After k=7 → WAIT:
  - WAIT holds BFLY_LAT cycles so the last write-back of stage s lands before stage s+1 reads it.
  - Then s<3 → CALC with s+1 and k=0; s=3 → UNLOAD with n=0.
- Write-back:
  - A BFLY_LAT-deep shift register of {valid, a, b} drives the o_wb_* outputs.
  - o_wb_valid mirrors o_bfly_valid delayed by exactly BFLY_LAT cycles.
- UNLOAD:
  - o_out_addr advances only when o_out_valid & i_out_ready.
  - After the 16th accepted output → DONE.
- DONE: o_done=1 for one cycle → IDLE.
- Address ordering between LOAD and UNLOAD is set by the macro (see Configuration). Output order is always natural, X[0]..X[15].

## Timing
- Reset, asynchronous and taking effect at any time including mid-frame:
  - State returns to IDLE.
  - All counters and the write-back pipe clear.
  - Every output reads 0.
- All outputs are registered except o_we, which is combinational.
- o_in_ready rises the cycle after i_start is sampled.
- CALC+WAIT takes exactly 4·(8+BFLY_LAT) cycles; 40 cycles at the default setting.
- Full frame with no stalls: 1 + 16 + 40 + 16 + 1 cycles.
- i_out_ready low holds o_out_addr stable and o_out_valid high indefinitely.
- i_in_valid low in LOAD stalls without limit. No timeout.

## Configuration
- FFT_SEQ_BITREV_EN defined:
  - LOAD writes to o_wr_addr = bitrev4(n).
  - UNLOAD reads o_out_addr = n.
- Not defined:
  - LOAD writes to o_wr_addr = n.
  - UNLOAD reads o_out_addr = bitrev4(n).
  - The datapath must then run DIF ordering: stage s uses h = 8>>s and tw = pos<<s, and the stages still progress s=0..3.

## Test plan
- Reset, then i_start pulse, then 16 back-to-back valid inputs, macro defined:
  - o_wr_addr sequence 0,8,4,12,2,…,15.
  - o_done pulses at cycle 74 after start.
- Stage issue order, BFLY_LAT=2:
  - s=1, k=5 → a=9, b=11, tw=4.
  - s=2, k=6 → a=10, b=14, tw=4.
  - A WAIT of 2 cycles separates every stage.
- Write-back alignment, BFLY_LAT=3:
  - Every o_wb_valid appears exactly 3 cycles after its o_bfly_valid, with matching addresses.
  - 32 write-backs total.
- Backpressure:
  - i_out_ready toggling 1,0,0,1 → each o_out_addr is held until accepted.
  - Exactly 16 acceptances before o_done.
- i_rst asserted during CALC at s=2:
  - All outputs are 0 immediately.
  - A subsequent i_start runs a complete frame from LOAD.
  - An i_start pulse during LOAD has no effect.
- Macro undefined:
  - Natural o_wr_addr 0..15.
  - o_out_addr order 0,8,4,12,…,15.
  - Stage 0 issues (0,8,tw0), (1,9,tw1).
